// File: rtl/counter_run_ctrl_if.sv
// Command/status bundle for counter_run_ctrl: a valid/ready command channel
// plus the count and status flags the sequencer publishes.
// slave = the sequencer; master = the software-facing controller driving commands.
interface counter_run_ctrl_if #(
    parameter int WIDTH = 3,
    parameter int PRE_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_limit;
    logic [PRE_W-1:0] cmd_prescale;
    logic             cmd_periodic;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             done;
    logic             err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_limit, cmd_prescale, cmd_periodic,
        output cmd_ready, count, busy, paused, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_limit, cmd_prescale, cmd_periodic,
        input  cmd_ready, count, busy, paused, done, err
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// Purpose: run-control sequencer owning a prescaled WIDTH-bit counter; START/STOP/PAUSE/RESUME commands.
// Latency: command effect visible next cycle; done/err are registered one-cycle pulses.
// Backpressure: cmd_ready is low only during the single DONE cycle; a held command is taken the cycle after.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the command channel,
//        count, busy, paused, done and err.
module counter_run_ctrl #(
    parameter int WIDTH = 3,
    parameter int PRE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    counter_run_ctrl_if.slave    bus
);
    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [PRE_W-1:0] pre_cnt;
    logic [WIDTH-1:0] limit_q;
    logic [PRE_W-1:0] prescale_q;
    logic             periodic_q;
    logic             done;
    logic             err;

    logic             ready;
    logic             accept;

    assign ready  = (state != S_DONE);
    assign accept = bus.cmd_valid && ready;

    assign bus.cmd_ready = ready;
    assign bus.busy      = (state == S_RUN) || (state == S_PAUSE);
    assign bus.paused    = (state == S_PAUSE);
    assign bus.count     = count;
    assign bus.done      = done;
    assign bus.err       = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            pre_cnt    <= '0;
            limit_q    <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (state == S_DONE) begin
                // DONE never accepts a command and always falls back to IDLE.
                state <= S_IDLE;
            end else if (accept) begin
                // An accepted command wins over a tick in the same cycle; that tick is dropped,
                // so pre_cnt stays at prescale and the tick fires on the next RUN cycle.
                unique case (bus.cmd_op)
                    OP_START: begin
                        limit_q    <= bus.cmd_limit;
                        prescale_q <= bus.cmd_prescale;
                        periodic_q <= bus.cmd_periodic;
                        count      <= '0;
                        pre_cnt    <= '0;
                        state      <= S_RUN;
                    end
                    OP_STOP: begin
                        pre_cnt <= '0;
                        state   <= S_IDLE;
                    end
                    OP_PAUSE: begin
                        if (state == S_RUN) state <= S_PAUSE;
                        else                err   <= 1'b1;
                    end
                    OP_RESUME: begin
                        if (state == S_PAUSE) state <= S_RUN;
                        else                  err   <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (state == S_RUN) begin
                if (pre_cnt == prescale_q) begin
                    pre_cnt <= '0;
                    if (count != limit_q) begin
                        count <= count + WIDTH'(1);
                    end else begin
                        // Terminal count: count never passes limit, so no wrap is possible.
                        done <= 1'b1;
                        if (periodic_q) count <= '0;
                        else            state <= S_DONE;
                    end
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/counter_run_ctrl.md
# counter_run_ctrl

Run-control sequencer for the small bit counters. It owns a WIDTH-bit count register and a prescaler, and it accepts START/STOP/PAUSE/RESUME commands over a valid/ready handshake. It produces the count, status flags, and a terminal-count `done` pulse, and it supports one-shot and periodic modes. Timer and LED/display blocks use it instead of free-running ripple counters when they need software-controlled start, stop and terminal events.

## Interface
- `WIDTH`, 3: count width; also the width of the terminal limit.
- `PRE_W`, 4: prescaler width; one count tick every `prescale+1` clocks.

- `clk`  in  1  system clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted; low only in DONE.
- `cmd_op`  in  2  command: 00 START, 01 STOP, 10 PAUSE, 11 RESUME.
- `cmd_limit`  in  WIDTH  terminal count; captured on START only.
- `cmd_prescale`  in  PRE_W  prescale value; captured on START only.
- `cmd_periodic`  in  1  1 = periodic, 0 = one-shot; captured on START only.
- `count`  out  WIDTH  current count (registered).
- `busy`  out  1  state is RUN or PAUSE.
- `paused`  out  1  state is PAUSE.
- `done`  out  1  one-cycle pulse on terminal count.
- `err`  out  1  one-cycle pulse on an illegal command.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Reset values:** state IDLE; `count`, `pre_cnt` and all captured registers 0; `done`, `err`, `busy`, `paused` 0; `cmd_ready` 1.
- **Accept:** a command is accepted when `cmd_valid && cmd_ready`.
- **START** (IDLE, RUN or PAUSE):
  - capture limit, prescale and mode; `count` ← 0; `pre_cnt` ← 0; next state RUN.
  - START while in RUN restarts the count.
- **STOP:**
  - from any non-DONE state: next state IDLE; `count` holds its value; `pre_cnt` ← 0.
  - STOP in IDLE is a legal no-op.
- **PAUSE:** RUN → PAUSE; `count` and `pre_cnt` are frozen.
- **RESUME:** PAUSE → RUN; the prescaler continues from its frozen value.
- **Illegal commands** (PAUSE outside RUN, RESUME outside PAUSE): `err` pulses the next cycle; state and counters are unchanged.
- **Tick:** `tick` = (state == RUN) && (`pre_cnt` == prescale) && no command accepted this cycle.
  - In RUN without a tick, `pre_cnt` increments.
  - On a tick, `pre_cnt` ← 0.
- **On tick:**
  - If `count` != limit: `count` ← `count` + 1.
  - Terminal (`count` == limit), one-shot: `count` holds at limit; next state DONE; `done` pulses.
  - Terminal, periodic: `count` ← 0; state stays RUN; `done` pulses.
- **DONE:** lasts exactly one cycle, then IDLE unconditionally. `cmd_ready` = 0 in DONE, so a held command is accepted in the following cycle.
- **Command priority:** an accepted command takes priority over a tick in the same cycle, and that tick is lost.
  - Example: PAUSE on a tick cycle leaves `pre_cnt` == prescale, so the tick fires on the first RUN cycle after RESUME.
- **limit = 0:** every tick is terminal.
- **No overflow:** `count` never exceeds limit, so the WIDTH-bit arithmetic never wraps unintentionally.

## Timing
- START accepted at cycle T gives state RUN at T+1.
- Tick k (k ≥ 0) occurs at cycle T+1+P+k(P+1), where P is the captured prescale.
  - The count update from tick k is visible one cycle later.
- `done` is registered. It is high in the cycle after the terminal tick, which is cycle T+2+P+L(P+1) for limit L.
  - In periodic mode this is the same cycle `count` shows 0.
- `err` is high in the cycle after the illegal command.
- `busy`, `paused` and `cmd_ready` decode the current state register with no added latency.
- Asserting `rst_n` low forces all outputs to their reset values immediately, without a clock edge, and aborts any run.
- Deasserting `rst_n` is synchronized by the integrator; the block needs no extra cycles after release.

## Test plan
- **One-shot:** reset; START limit=5, P=0, one-shot at cycle 0.
  - `count` = 1..5 in cycles 2..6.
  - `done`=1 and `cmd_ready`=0 at cycle 7, with `count` held at 5.
  - IDLE with `busy`=0 at cycle 8.
- **Periodic wrap:** START limit=7, P=1, periodic.
  - `count` steps every 2 cycles: 0→7, then wraps to 0 with `done` pulsing.
  - `done` pulses every 16 cycles; `count` never exceeds 7.
- **Zero limit:** START limit=0, P=2, periodic.
  - `count` stays 0; `done` pulses every 3 cycles.
- **Pause on tick:** issue PAUSE in a tick cycle of a limit=6, P=3 run; RESUME 4 cycles later.
  - `count` is unchanged across the pause and through the RESUME cycle.
  - `count` increments one cycle after the first RUN cycle following RESUME.
- **Illegal and blocked commands:**
  - RESUME in IDLE → `err`=1 for one cycle; state stays IDLE.
  - PAUSE in PAUSE → `err`=1; state stays PAUSE.
  - A STOP held valid during DONE is accepted in the IDLE cycle after DONE.
- **Restart and reset:**
  - START mid-run with limit=3 → `count`=0 next cycle, then a fresh sequence to 3.
  - `rst_n` pulled low between clock edges mid-run → `count`=0, `busy`=0, `cmd_ready`=1 immediately.
